temp_average_divider: RTL

//  Sequential stage directly downstream of the sensor sum/count stage. Divides
//  the 16-bit temperature sum by the active-sensor count, one quotient bit per

---
 rtl/temp_average_divider_pkg.sv | 18 +
 rtl/temp_average_divider_div_step.sv | 31 +++
 rtl/temp_average_divider.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/temp_average_divider_pkg.sv
// Shared constants for the temperature average divider: FSM encoding and default widths/thresholds.
// No logic, no latency.
// No flow control.
package temp_average_divider_pkg;

    localparam int SUM_W_DEF = 16;
    localparam int CNT_W_DEF = 8;

    localparam logic [15:0] HOT_TH_DEF  = 16'd40;
    localparam logic [15:0] COLD_TH_DEF = 16'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/temp_average_divider_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
// Combinational, zero latency.
// No flow control.
module temp_average_divider_div_step #(
    parameter int CNT_W = 8
) (
    input  logic [CNT_W:0]   rem_in,
    input  logic             dvd_bit,
    input  logic [CNT_W-1:0] divisor,
    output logic [CNT_W:0]   rem_out,
    output logic             q_bit
);

    logic [CNT_W:0] shifted;
    logic [CNT_W:0] dvs_ext;

    // Incoming remainder is always below the divisor, so its top bit is zero and
    // the left shift never loses information.
    assign shifted = {rem_in[CNT_W-1:0], dvd_bit};
    assign dvs_ext = {1'b0, divisor};

    always_comb begin
        q_bit   = 1'b0;
        rem_out = shifted;
        if (shifted >= dvs_ext) begin
            q_bit   = 1'b1;
            rem_out = shifted - dvs_ext;
        end
    end

endmodule

// File: rtl/temp_average_divider.sv
// Averages the temperature sum over the active-sensor count with a bit-serial restoring divider plus hot/cold alarms.
// Latency: valid_o one cycle, SUM_W+1 edges after accept (1 edge when count is zero).
// start_i is only taken while idle and not busy; requests during a division are dropped.
module temp_average_divider
    import temp_average_divider_pkg::*;
#(
    parameter int                SUM_W   = SUM_W_DEF,
    parameter int                CNT_W   = CNT_W_DEF,
    parameter logic [SUM_W-1:0]  HOT_TH  = SUM_W'(HOT_TH_DEF),
    parameter logic [SUM_W-1:0]  COLD_TH = SUM_W'(COLD_TH_DEF),
    parameter bit                ROUND   = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [SUM_W-1:0] temp_sum_i,
    input  logic [CNT_W-1:0] nr_active_sensors_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [SUM_W-1:0] avg_o,
    output logic [CNT_W-1:0] rem_o,
    output logic             err_no_sensor_o,
    output logic             alert_hot_o,
    output logic             alert_cold_o
);

    localparam int CW = $clog2(SUM_W + 1);

    state_t           state_q, state_d;
    logic             accept;
    logic [SUM_W-1:0] dq_q;
    logic [CNT_W:0]   prem_q;
    logic [CNT_W-1:0] dvs_q;
    logic [CW-1:0]    cnt_q;

    logic [CNT_W:0]   step_rem;
    logic             step_q;

    logic             dvs_zero;
    logic             round_up;
    logic [SUM_W-1:0] avg_d;
    logic [CNT_W-1:0] rem_d;

    temp_average_divider_div_step #(
        .CNT_W (CNT_W)
    ) u_step (
        .rem_in  (prem_q),
        .dvd_bit (dq_q[SUM_W-1]),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // busy_o is still high in the cycle valid_o is shown
                if (start_i && !busy_o) begin
                    accept  = 1'b1;
                    state_d = (nr_active_sensors_i == '0) ? ST_DONE : ST_DIV;
                end
            end
            ST_DIV: begin
                if (cnt_q == CW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Once the iterations finish, dq_q holds the quotient and prem_q the remainder.
    always_comb begin
        dvs_zero = (dvs_q == '0);
        round_up = ROUND && ({prem_q[CNT_W-1:0], 1'b0} >= {1'b0, dvs_q});
        avg_d    = '0;
        rem_d    = '0;
        if (!dvs_zero) begin
            avg_d = dq_q + SUM_W'(round_up);
            rem_d = prem_q[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dq_q   <= '0;
            prem_q <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
        end else if (accept) begin
            dq_q   <= temp_sum_i;
            prem_q <= '0;
            dvs_q  <= nr_active_sensors_i;
            cnt_q  <= CW'(SUM_W);
        end else if (state_q == ST_DIV) begin
            dq_q   <= {dq_q[SUM_W-2:0], step_q};
            prem_q <= step_rem;
            cnt_q  <= cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            busy_o          <= 1'b0;
            valid_o         <= 1'b0;
            avg_o           <= '0;
            rem_o           <= '0;
            err_no_sensor_o <= 1'b0;
            alert_hot_o     <= 1'b0;
            alert_cold_o    <= 1'b0;
        end else begin
            if (accept) begin
                busy_o <= 1'b1;
            end
            if (state_q == ST_DONE) begin
                valid_o         <= 1'b1;
                avg_o           <= avg_d;
                rem_o           <= rem_d;
                err_no_sensor_o <= dvs_zero;
                alert_hot_o     <= (avg_d > HOT_TH);
                alert_cold_o    <= (avg_d < COLD_TH);
            end else if (valid_o) begin
                valid_o <= 1'b0;
                busy_o  <= 1'b0;
            end
        end
    end

endmodule
